// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder_cell.sv
// One-bit half adder; two of these plus an OR form the serial full-adder bit.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder bit.
// Define SERIAL_ADD_SUB_EN to add the op_sub port (A - B via ~B and carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

    logic             ha0_sum;
    logic             ha0_carry;
    logic             bit_sum;
    logic             ha1_carry;
    logic             bit_carry;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == LAST_CNT);

    // Subtraction is A + ~B + 1; the mode is captured only through the loaded B and carry.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = op_sub ? ~op_b : op_b;
    assign carry_init = op_sub;
`else
    assign b_load     = op_b;
    assign carry_init = 1'b0;
`endif

    half_adder_cell u_ha0 (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_adder_cell u_ha1 (
        .a     (ha0_sum),
        .b     (carry_q),
        .sum   (bit_sum),
        .carry (ha1_carry)
    );

    assign bit_carry = ha0_carry | ha1_carry;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the shift registers are plain flops, not a memory array, so they
    // are cheap to clear and the reset result is fully defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= b_load;
            carry_q <= carry_init;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= {bit_sum, sum_q[WIDTH-1:1]};
            carry_q <= bit_carry;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule
